exposure_ctrl: RTL and testbench

//  Initiator side of the exposure timer interface: drives Initial/Start into

---
 rtl/exposure_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_exposure_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exposure_ctrl.sv
// -----------------------------------------------------------------------------
// exposure_ctrl
//
// Initiator side of the exposure timer interface. Drives Initial/Start into the
// external Timer_counter and consumes its Ovf5 overflow flag. Sequences the
// pixel array through IDLE -> EXPOSE -> READOUT (R0..R7) and holds the
// user-adjustable exposure time.
//
// Ports
//   Clk          in   1  system clock, rising edge
//   Reset        in   1  asynchronous, active-low reset
//   Init         in   1  start one exposure cycle (level, sampled in IDLE)
//   Exp_increase in   1  raise exposure by EXP_STEP (IDLE only)
//   Exp_decrease in   1  lower exposure by EXP_STEP (IDLE only)
//   Ovf5         in   1  timer overflow, only meaningful in EXPOSE
//   Initial      out  5  exposure value handed to the timer
//   Start        out  1  one-cycle timer start pulse
//   Erase        out  1  pixel erase, high in IDLE
//   Expose       out  1  pixel expose, high in EXPOSE
//   NRE_1        out  1  row-1 read enable, active-low
//   NRE_2        out  1  row-2 read enable, active-low
//   ADC          out  1  ADC convert strobe, one cycle per row
//   Busy         out  1  high outside IDLE
//   Err          out  1  sticky watchdog flag, cleared by the next accepted Init
//
// Every output is a flop. The decode logic works on the *next* state so that
// each registered output lines up with the state it belongs to, with no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------
module exposure_ctrl #(
    parameter int unsigned EXP_MIN  = 2,
    parameter int unsigned EXP_MAX  = 30,
    parameter int unsigned EXP_DEF  = 16,
    parameter int unsigned EXP_STEP = 1,
    parameter int unsigned TIMEOUT  = 63
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Init,
    input  logic       Exp_increase,
    input  logic       Exp_decrease,
    input  logic       Ovf5,
    output logic [4:0] Initial,
    output logic       Start,
    output logic       Erase,
    output logic       Expose,
    output logic       NRE_1,
    output logic       NRE_2,
    output logic       ADC,
    output logic       Busy,
    output logic       Err
);

    // Exposure arithmetic is done at 6 bits so a step past 31 cannot wrap.
    localparam logic [5:0] C_EXP_MIN   = 6'(EXP_MIN);
    localparam logic [5:0] C_EXP_MAX   = 6'(EXP_MAX);
    localparam logic [5:0] C_EXP_DEF   = 6'(EXP_DEF);
    localparam logic [5:0] C_EXP_STEP  = 6'(EXP_STEP);
    // Watchdog value seen on the last EXPOSE cycle before a timeout.
    localparam logic [5:0] C_WDOG_LAST = 6'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_EXPOSE,
        S_R0,
        S_R1,
        S_R2,
        S_R3,
        S_R4,
        S_R5,
        S_R6,
        S_R7
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic       w_accept;       // Init taken in IDLE this cycle
    logic       w_timeout;      // watchdog expired without Ovf5

    logic [4:0] r_exp_time;
    logic [4:0] w_exp_nxt;
    logic [5:0] w_exp_sum;
    logic [4:0] w_exp_up;
    logic [4:0] w_exp_dn;

    logic [5:0] r_wdog;
    logic [5:0] w_wdog_nxt;

    logic [4:0] r_initial;
    logic       r_start;
    logic       r_erase;
    logic       r_expose;
    logic       r_nre_1;
    logic       r_nre_2;
    logic       r_adc;
    logic       r_busy;
    logic       r_err;

    logic       w_erase_nxt;
    logic       w_expose_nxt;
    logic       w_nre_1_nxt;
    logic       w_nre_2_nxt;
    logic       w_adc_nxt;
    logic       w_busy_nxt;

    // -------------------------------------------------------------------------
    // FSM process 1: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default before the case; a path that leaves a
    // combinational signal unassigned would infer a latch.
    always_comb begin : next_state_logic
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (Init) begin
                    w_state_nxt = S_EXPOSE;
                    w_accept    = 1'b1;
                end
            end
            S_EXPOSE: begin
                // Ovf5 wins over a watchdog expiry in the same cycle.
                if (Ovf5) begin
                    w_state_nxt = S_R0;
                end else if (r_wdog == C_WDOG_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            S_R0:    w_state_nxt = S_R1;
            S_R1:    w_state_nxt = S_R2;
            S_R2:    w_state_nxt = S_R3;
            S_R3:    w_state_nxt = S_R4;
            S_R4:    w_state_nxt = S_R5;
            S_R5:    w_state_nxt = S_R6;
            S_R6:    w_state_nxt = S_R7;
            S_R7:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM process 3: output decode (from next state, registered below)
    // -------------------------------------------------------------------------
    always_comb begin : output_decode
        w_erase_nxt  = (w_state_nxt == S_IDLE);
        w_expose_nxt = (w_state_nxt == S_EXPOSE);
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        w_nre_1_nxt  = 1'b1;
        w_nre_2_nxt  = 1'b1;
        w_adc_nxt    = 1'b0;
        unique case (w_state_nxt)
            S_R0, S_R2: w_nre_1_nxt = 1'b0;
            S_R1: begin
                w_nre_1_nxt = 1'b0;
                w_adc_nxt   = 1'b1;
            end
            S_R4, S_R6: w_nre_2_nxt = 1'b0;
            S_R5: begin
                w_nre_2_nxt = 1'b0;
                w_adc_nxt   = 1'b1;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Exposure time adjust (IDLE only, Init has priority, both high = hold)
    // -------------------------------------------------------------------------
    assign w_exp_sum = {1'b0, r_exp_time} + C_EXP_STEP;
    assign w_exp_up  = (w_exp_sum > C_EXP_MAX) ? C_EXP_MAX[4:0] : w_exp_sum[4:0];
    assign w_exp_dn  = ({1'b0, r_exp_time} < (C_EXP_MIN + C_EXP_STEP))
                       ? C_EXP_MIN[4:0]
                       : (r_exp_time - C_EXP_STEP[4:0]);

    always_comb begin : exp_adjust
        w_exp_nxt = r_exp_time;
        if ((r_state == S_IDLE) && !Init) begin
            if (Exp_increase && !Exp_decrease) begin
                w_exp_nxt = w_exp_up;
            end else if (Exp_decrease && !Exp_increase) begin
                w_exp_nxt = w_exp_dn;
            end
        end
    end

    // Watchdog runs only while in EXPOSE and restarts from zero on each entry.
    assign w_wdog_nxt = (r_state == S_EXPOSE) ? (r_wdog + 6'd1) : 6'd0;

    // -------------------------------------------------------------------------
    // Datapath and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_exp_time <= C_EXP_DEF[4:0];
            r_wdog     <= 6'd0;
            r_initial  <= C_EXP_DEF[4:0];
            r_start    <= 1'b0;
            r_erase    <= 1'b1;
            r_expose   <= 1'b0;
            r_nre_1    <= 1'b1;
            r_nre_2    <= 1'b1;
            r_adc      <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_exp_time <= w_exp_nxt;
            r_wdog     <= w_wdog_nxt;
            // Initial is loaded only on accept, so it stays frozen from Start
            // until the timer overflows.
            if (w_accept) begin
                r_initial <= r_exp_time;
            end
            r_start  <= w_accept;
            r_erase  <= w_erase_nxt;
            r_expose <= w_expose_nxt;
            r_nre_1  <= w_nre_1_nxt;
            r_nre_2  <= w_nre_2_nxt;
            r_adc    <= w_adc_nxt;
            r_busy   <= w_busy_nxt;
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign Initial = r_initial;
    assign Start   = r_start;
    assign Erase   = r_erase;
    assign Expose  = r_expose;
    assign NRE_1   = r_nre_1;
    assign NRE_2   = r_nre_2;
    assign ADC     = r_adc;
    assign Busy    = r_busy;
    assign Err     = r_err;

endmodule

// File: tb/tb_exposure_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exposure_ctrl
//
// Drives exposure_ctrl from a negedge stimulus process. For every cycle the
// stimulus asks a behavioural model (mode + phase counter + plain integer
// arithmetic) what the outputs must look like after the next rising edge and
// queues that expectation. A monitor pops one expectation per rising edge and
// compares all outputs. A simple timer model raises Ovf5 when the number of
// EXPOSE cycles reaches the value the model expects on Initial.
// -----------------------------------------------------------------------------
module tb_exposure_ctrl;

    localparam int EXP_MIN  = 2;
    localparam int EXP_MAX  = 30;
    localparam int EXP_DEF  = 16;
    localparam int EXP_STEP = 1;
    localparam int TIMEOUT  = 63;

    logic       Clk          = 1'b0;
    logic       Reset        = 1'b0;
    logic       Init         = 1'b0;
    logic       Exp_increase = 1'b0;
    logic       Exp_decrease = 1'b0;
    logic       Ovf5         = 1'b0;
    logic [4:0] Initial;
    logic       Start;
    logic       Erase;
    logic       Expose;
    logic       NRE_1;
    logic       NRE_2;
    logic       ADC;
    logic       Busy;
    logic       Err;

    exposure_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Init         (Init),
        .Exp_increase (Exp_increase),
        .Exp_decrease (Exp_decrease),
        .Ovf5         (Ovf5),
        .Initial      (Initial),
        .Start        (Start),
        .Erase        (Erase),
        .Expose       (Expose),
        .NRE_1        (NRE_1),
        .NRE_2        (NRE_2),
        .ADC          (ADC),
        .Busy         (Busy),
        .Err          (Err)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [4:0] initial_v;
        logic       start;
        logic       erase;
        logic       expose;
        logic       nre_1;
        logic       nre_2;
        logic       adc;
        logic       busy;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    typedef enum { M_IDLE, M_EXPOSE, M_READOUT } mmode_t;

    mmode_t m_mode;
    int     m_phase;     // readout row-step 0..7
    int     m_exp;       // user exposure setting
    int     m_initial;   // value latched for the timer
    int     m_wd;        // edges already spent in EXPOSE
    bit     m_err;

    bit     rst_val;     // Reset level to apply on the next negedge
    bit     tmr_en;      // timer model produces Ovf5
    bit     hold_next;   // stretch the next Ovf5 to two cycles
    bit     ovf_hold;

    function automatic void model_reset();
        m_mode    = M_IDLE;
        m_phase   = 0;
        m_exp     = EXP_DEF;
        m_initial = EXP_DEF;
        m_wd      = 0;
        m_err     = 1'b0;
    endfunction

    // Advance the model by one rising edge; returns whether Start pulses.
    function automatic bit model_step(bit init, bit inc, bit dec, bit ovf);
        bit start;
        start = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (init) begin
                    m_mode    = M_EXPOSE;
                    m_wd      = 0;
                    m_initial = m_exp;
                    m_err     = 1'b0;
                    start     = 1'b1;
                end else if (inc && !dec) begin
                    m_exp = (m_exp + EXP_STEP > EXP_MAX) ? EXP_MAX : m_exp + EXP_STEP;
                end else if (dec && !inc) begin
                    m_exp = (m_exp - EXP_STEP < EXP_MIN) ? EXP_MIN : m_exp - EXP_STEP;
                end
            end
            M_EXPOSE: begin
                m_wd++;
                if (ovf) begin
                    m_mode  = M_READOUT;
                    m_phase = 0;
                end else if (m_wd == TIMEOUT) begin
                    m_err  = 1'b1;
                    m_mode = M_IDLE;
                end
            end
            default: begin
                if (m_phase == 7) m_mode = M_IDLE;
                else              m_phase++;
            end
        endcase
        return start;
    endfunction

    function automatic exp_t model_outputs(bit start);
        exp_t e;
        e.initial_v = 5'(m_initial);
        e.start     = start;
        e.erase     = (m_mode == M_IDLE);
        e.expose    = (m_mode == M_EXPOSE);
        // Row 1 occupies steps 0..2, row 2 steps 4..6, ADC mid-row.
        e.nre_1     = !(m_mode == M_READOUT && m_phase <= 2);
        e.nre_2     = !(m_mode == M_READOUT && m_phase >= 4 && m_phase <= 6);
        e.adc       = (m_mode == M_READOUT) && (m_phase % 4 == 1);
        e.busy      = (m_mode != M_IDLE);
        e.err       = m_err;
        return e;
    endfunction

    // ------------------------------------------------------------ stimulus
    task automatic drive_cycle(input bit init, input bit inc, input bit dec, input bit stray);
        bit ovf;
        bit start;
        @(negedge Clk);
        Reset = rst_val;
        // Stray overflows only outside EXPOSE; inside EXPOSE the timer decides.
        ovf = stray && (m_mode != M_EXPOSE);
        if (m_mode == M_EXPOSE && tmr_en && (m_wd + 1 == m_initial)) begin
            ovf      = 1'b1;
            ovf_hold = hold_next;
        end else if (ovf_hold) begin
            ovf      = 1'b1;
            ovf_hold = 1'b0;
        end
        Init         = init;
        Exp_increase = inc;
        Exp_decrease = dec;
        Ovf5         = ovf;
        if (!rst_val) begin
            model_reset();
            ovf_hold = 1'b0;
            start    = 1'b0;
        end else begin
            start = model_step(init, inc, dec, ovf);
        end
        sb_q.push_back(model_outputs(start));
    endtask

    task automatic run_until_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (m_mode == M_IDLE) break;
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // ------------------------------------------------------------- monitor
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("Initial", 32'(Initial), 32'(e.initial_v));
                check("Start",   32'(Start),   32'(e.start));
                check("Erase",   32'(Erase),   32'(e.erase));
                check("Expose",  32'(Expose),  32'(e.expose));
                check("NRE_1",   32'(NRE_1),   32'(e.nre_1));
                check("NRE_2",   32'(NRE_2),   32'(e.nre_2));
                check("ADC",     32'(ADC),     32'(e.adc));
                check("Busy",    32'(Busy),    32'(e.busy));
                check("Err",     32'(Err),     32'(e.err));
            end
        end
    end

    initial begin : sim_guard
        #2000000;
        $display("FAIL sim_timeout: bench did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin : stimulus
        rst_val   = 1'b0;
        tmr_en    = 1'b1;
        hold_next = 1'b0;
        ovf_hold  = 1'b0;
        model_reset();

        // Reset held, then released with Init low.
        repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        rst_val = 1'b1;
        repeat (5) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // One full exposure with the default value.
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_until_idle(100);

        // Adjust: saturate high, saturate low, both held, then a few steps up.
        repeat (20) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (40) drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3)  drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (5)  drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);

        // Exposure with Exp_increase held throughout (ignored), stretched Ovf5.
        hold_next = 1'b1;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (m_mode == M_IDLE) break;
            drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        end
        hold_next = 1'b0;

        // Watchdog timeout, then the next Init clears Err.
        tmr_en = 1'b0;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_until_idle(100);
        tmr_en = 1'b1;
        repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_until_idle(100);

        // Asynchronous reset in the middle of R1.
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (m_mode == M_READOUT && m_phase == 1) break;
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge Clk);
        Reset        = 1'b0;
        Init         = 1'b0;
        Exp_increase = 1'b0;
        Exp_decrease = 1'b0;
        Ovf5         = 1'b0;
        #1;
        check("async_NRE_1",   32'(NRE_1),   32'd1);
        check("async_ADC",     32'(ADC),     32'd0);
        check("async_Erase",   32'(Erase),   32'd1);
        check("async_Busy",    32'(Busy),    32'd0);
        check("async_Start",   32'(Start),   32'd0);
        check("async_Initial", 32'(Initial), 32'(EXP_DEF));
        rst_val = 1'b0;
        model_reset();
        ovf_hold = 1'b0;
        sb_q.push_back(model_outputs(1'b0));
        repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        rst_val = 1'b1;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_until_idle(100);

        // Stray Ovf5 in IDLE and in R3, Init held during readout,
        // then Init together with Exp_increase.
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (m_mode == M_READOUT && m_phase == 3) break;
            drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        run_until_idle(20);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        run_until_idle(100);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_until_idle(100);

        // Randomised traffic with occasional missing overflows and resets.
        for (int i = 0; i < 2500; i++) begin
            if (m_mode == M_IDLE) begin
                tmr_en    = ($urandom_range(0, 7) != 0);
                hold_next = ($urandom_range(0, 1) != 0);
            end
            rst_val = ($urandom_range(0, 399) != 0);
            drive_cycle($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                        $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
        end
        rst_val = 1'b1;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);

        @(posedge Clk);
        #2;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
